// File: rtl/taylor_stage_1_ctrl.sv
// Horner sequencer for Taylor stage 1: P(x) = (x/720 + 1/120)*x + 1/24; TAYLOR_CTRL_BACK2BACK_EN lets HOLD restart directly.
// Latency: OUT_VALID rises on the fifth edge counting the edge that accepts START (MUL1..ADD2 then HOLD).
// Backpressure: RESULT/OUT_VALID hold in HOLD until OUT_READY; START outside IDLE is dropped, not queued.
module taylor_stage_1_ctrl #(
    parameter int WIDTH  = 26,
    parameter int FRAC_W = 23
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] IN_X,
    output logic             BUSY,
    output logic [WIDTH-1:0] A_OUT,
    output logic             mul_ss,
    output logic             add_ss,
    output logic             mul_ss_en,
    output logic             add_ss_en,
    input  logic [WIDTH-1:0] STAGE_OUT,
    output logic [WIDTH-1:0] RESULT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    if (FRAC_W != WIDTH - 3) begin : g_frac_check
        $error("FRAC_W must equal WIDTH-3");
    end

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL1 = 3'd1;
    localparam logic [2:0] S_ADD1 = 3'd2;
    localparam logic [2:0] S_MUL2 = 3'd3;
    localparam logic [2:0] S_ADD2 = 3'd4;
    localparam logic [2:0] S_HOLD = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = IN_X;
                    state_d = S_MUL1;
                end
            end
            S_MUL1: state_d = S_ADD1;
            S_ADD1: state_d = S_MUL2;
            S_MUL2: state_d = S_ADD2;
            S_ADD2: begin
                // STAGE_OUT here is reg_mul + 1/24, the finished polynomial
                result_d = STAGE_OUT;
                valid_d  = 1'b1;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    valid_d = 1'b0;
`ifdef TAYLOR_CTRL_BACK2BACK_EN
                    if (START) begin
                        a_d     = IN_X;
                        state_d = S_MUL1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath controls are pure state decodes so they never see input glitches
    always_comb begin
        mul_ss    = 1'b0;
        add_ss    = 1'b0;
        mul_ss_en = 1'b0;
        add_ss_en = 1'b0;
        case (state_q)
            S_MUL1: begin
                mul_ss    = 1'b1;
                mul_ss_en = 1'b1;
            end
            S_ADD1: begin
                add_ss    = 1'b1;
                add_ss_en = 1'b1;
            end
            S_MUL2:  mul_ss_en = 1'b1;
            S_ADD2:  add_ss_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign A_OUT     = a_q;
    assign RESULT    = result_q;
    assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_taylor_stage_1_ctrl.sv
// Directed bench for taylor_stage_1_ctrl with a bit-exact 3.23 stage-1 datapath attached.
module tb_taylor_stage_1_ctrl;

    localparam int WIDTH = 26;

    // 3.23 constants, truncated: 2^23/720, 2^23/120, 2^23/24
    localparam logic [WIDTH-1:0] C720 = 26'h0002D82;
    localparam logic [WIDTH-1:0] C120 = 26'h0011111;
    localparam logic [WIDTH-1:0] C24  = 26'h0055555;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [WIDTH-1:0] IN_X;
    logic             BUSY;
    logic [WIDTH-1:0] A_OUT;
    logic             mul_ss, add_ss, mul_ss_en, add_ss_en;
    logic [WIDTH-1:0] STAGE_OUT;
    logic [WIDTH-1:0] RESULT;
    logic             OUT_VALID;
    logic             OUT_READY;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 CLK = ~CLK;

    taylor_stage_1_ctrl #(.WIDTH(WIDTH), .FRAC_W(23)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .IN_X      (IN_X),
        .BUSY      (BUSY),
        .A_OUT     (A_OUT),
        .mul_ss    (mul_ss),
        .add_ss    (add_ss),
        .mul_ss_en (mul_ss_en),
        .add_ss_en (add_ss_en),
        .STAGE_OUT (STAGE_OUT),
        .RESULT    (RESULT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    // Datapath: multiplier truncates the 6.46 product back to 3.23
    logic [WIDTH-1:0]   reg_mul, reg_add;
    logic [2*WIDTH-1:0] prod;
    assign prod      = A_OUT * (mul_ss ? C720 : reg_add);
    assign STAGE_OUT = reg_mul + (add_ss ? C120 : C24);

    always @(posedge CLK) begin
        if (RST) begin
            reg_mul <= '0;
            reg_add <= '0;
        end else if (add_ss_en) begin
            reg_add <= STAGE_OUT;
        end else if (mul_ss_en) begin
            reg_mul <= prod[WIDTH+22:23];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ctrl();
        return {mul_ss, add_ss, mul_ss_en, add_ss_en};
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Entered at the negedge while in MUL1; leaves the DUT in HOLD.
    task automatic seq_check(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] exp, input bit noisy);
        logic [3:0] exp_ctrl [4];
        exp_ctrl[0] = 4'b1010;
        exp_ctrl[1] = 4'b0101;
        exp_ctrl[2] = 4'b0010;
        exp_ctrl[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            if (noisy) begin
                START = 1'b1;
                IN_X  = ~x;
            end
            chk($sformatf("ctrl_s%0d", i), 32'(ctrl()), 32'(exp_ctrl[i]));
            chk($sformatf("busy_s%0d", i), 32'(BUSY), 32'd1);
            chk($sformatf("a_out_s%0d", i), 32'(A_OUT), 32'(x));
            chk($sformatf("vld_s%0d", i), 32'(OUT_VALID), 32'd0);
            step();
        end
        chk("hold_valid", 32'(OUT_VALID), 32'd1);
        chk("hold_result", 32'(RESULT), 32'(exp));
        chk("hold_ctrl", 32'(ctrl()), 32'd0);
        chk("hold_busy", 32'(BUSY), 32'd1);
        START = 1'b0;
    endtask

    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] exp, input bit noisy);
        START = 1'b1;
        IN_X  = x;
        step();
        START = 1'b0;
        seq_check(x, exp, noisy);
    endtask

    task automatic release_out();
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("rel_valid", 32'(OUT_VALID), 32'd0);
        chk("rel_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        RST       = 1'b1;
        START     = 1'b0;
        IN_X      = '0;
        OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        step();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_a_out", 32'(A_OUT), 32'd0);
        chk("rst_result", 32'(RESULT), 32'd0);
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_ctrl", 32'(ctrl()), 32'd0);

        // x = 0 gives 1/24
        do_op(26'h0000000, 26'h0055555, 1'b0);
        release_out();

        // x = 1.0: 11650 + 69905 = 81555, *1, + 349525 = 431080
        do_op(26'h0800000, 26'h00693E8, 1'b1);
        for (int i = 0; i < 10; i++) begin
            START = 1'b1;
            IN_X  = 26'h1234567 + 26'(i);
            step();
            chk("stall_valid", 32'(OUT_VALID), 32'd1);
            chk("stall_result", 32'(RESULT), 32'h00693E8);
            chk("stall_a_out", 32'(A_OUT), 32'h0800000);
        end
        START = 1'b0;
        release_out();

        // Reset while in MUL2 aborts the sequence
        START = 1'b1;
        IN_X  = 26'h0800000;
        step();
        START = 1'b0;
        step();
        step();
        chk("pre_rst_ctrl", 32'(ctrl()), 32'b0010);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_ctrl", 32'(ctrl()), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_valid", 32'(OUT_VALID), 32'd0);
        chk("abort_result", 32'(RESULT), 32'd0);
        repeat (5) begin
            step();
            chk("abort_idle_valid", 32'(OUT_VALID), 32'd0);
        end

        // x = 2.0: 23300 + 69905 = 93205, *2 = 186410, + 349525 = 535935
        do_op(26'h1000000, 26'h0082D7F, 1'b0);
        release_out();

        // x = 0.5: 5825 + 69905 = 75730, /2 = 37865, + 349525 = 387390
        do_op(26'h0400000, 26'h005E93E, 1'b0);
        START     = 1'b1;
        IN_X      = 26'h1000000;
        OUT_READY = 1'b1;
        step();
        START     = 1'b0;
        OUT_READY = 1'b0;
`ifdef TAYLOR_CTRL_BACK2BACK_EN
        chk("b2b_valid", 32'(OUT_VALID), 32'd0);
        seq_check(26'h1000000, 26'h0082D7F, 1'b0);
        release_out();
`else
        chk("b2b_busy", 32'(BUSY), 32'd0);
        chk("b2b_valid", 32'(OUT_VALID), 32'd0);
        chk("b2b_a_out", 32'(A_OUT), 32'h0400000);
        repeat (6) begin
            step();
            chk("b2b_dropped_busy", 32'(BUSY), 32'd0);
            chk("b2b_dropped_valid", 32'(OUT_VALID), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
